// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - single-outstanding APB master with misalignment and wait-state timeout checks
// All outputs are registered: the comb process computes next values, the seq process stores them.
module apb_master_ctrl #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [DATA_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic [DATA_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLAVEERR
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];

   state_t                  state, state_next;
   logic [7:0]              wait_cnt, wait_cnt_d;
   logic                    req_ready_d, rsp_valid_d, rsp_err_d, rsp_timeout_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_d, paddr_d, pwdata_d;
   logic                    psel_d, penable_d, pwrite_d;

   always_comb begin
      state_next    = state;
      wait_cnt_d    = wait_cnt;
      req_ready_d   = 1'b0;
      rsp_valid_d   = 1'b0;
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
      rsp_rdata_d   = '0;
      psel_d        = 1'b0;
      penable_d     = 1'b0;
      paddr_d       = PADDR;
      pwdata_d      = PWDATA;
      pwrite_d      = PWRITE;

      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               if (req_addr[1:0] == 2'b00) begin
                  paddr_d    = req_addr;
                  pwdata_d   = req_wdata;
                  pwrite_d   = req_write;
                  psel_d     = 1'b1;
                  state_next = SETUP;
               end else begin
                  // Misaligned: report straight away, the bus is never touched.
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  state_next  = RESP;
               end
            end else begin
               req_ready_d = 1'b1;
            end
         end
         SETUP: begin
            psel_d     = 1'b1;
            penable_d  = 1'b1;
            wait_cnt_d = '0;
            state_next = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = PSLAVEERR;
               rsp_rdata_d = (!PWRITE && !PSLAVEERR) ? PRDATA : '0;
               state_next  = RESP;
            end else if (wait_cnt + 8'd1 == TIMEOUT_LIM) begin
               // This low-PREADY cycle brings the count to the limit: give up.
               wait_cnt_d    = wait_cnt + 8'd1;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               state_next    = RESP;
            end else begin
               wait_cnt_d = wait_cnt + 8'd1;
               psel_d     = 1'b1;
               penable_d  = 1'b1;
            end
         end
         RESP: begin
            req_ready_d = 1'b1;
            state_next  = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_rdata   <= '0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         PWRITE      <= 1'b0;
      end else begin
         state       <= state_next;
         wait_cnt    <= wait_cnt_d;
         req_ready   <= req_ready_d;
         rsp_valid   <= rsp_valid_d;
         rsp_err     <= rsp_err_d;
         rsp_timeout <= rsp_timeout_d;
         rsp_rdata   <= rsp_rdata_d;
         PSEL        <= psel_d;
         PENABLE     <= penable_d;
         PADDR       <= paddr_d;
         PWDATA      <= pwdata_d;
         PWRITE      <= pwrite_d;
      end
   end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb/tb_apb_master_ctrl.sv - directed vector bench for apb_master_ctrl (TIMEOUT_CYCLES = 4)
module tb_apb_master_ctrl;

   logic        PCLK = 1'b0;
   logic        PRESETn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic [31:0] PADDR, PWDATA;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PRDATA = '0;
   logic        PREADY = 1'b0;
   logic        PSLAVEERR = 1'b0;

   int tests = 0;
   int failed = 0;

   apb_master_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLAVEERR(PSLAVEERR)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      int          exp_lat;
      logic        exp_err;
      logic        exp_to;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[9];

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int k = 0;
      while (req_ready !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   first, nvalid;
      logic psel_seen, bus_bad, aligned;
      logic got_err, got_to;
      logic [31:0] got_rdata;
      v = vecs[idx];
      aligned = (v.addr[1:0] == 2'b00);
      first = -1; nvalid = 0; psel_seen = 0; bus_bad = 0;
      got_err = 0; got_to = 0; got_rdata = '0;
      wait_ready();
      req_valid = 1'b1;
      req_write = v.write;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      PREADY    = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (c == 1) req_valid = 1'b0;
         if (rsp_valid === 1'b1) begin
            if (first < 0) begin
               first = c;
               got_err = rsp_err;
               got_to = rsp_timeout;
               got_rdata = rsp_rdata;
            end
            nvalid++;
         end
         if (PSEL === 1'b1) begin
            psel_seen = 1'b1;
            if (PADDR !== v.addr || PWRITE !== v.write || (v.write && PWDATA !== v.wdata))
               bus_bad = 1'b1;
         end
         if (c == 1) begin
            chk($sformatf("v%0d_psel_n1", idx), {31'd0, PSEL}, {31'd0, aligned});
            chk($sformatf("v%0d_penable_n1", idx), {31'd0, PENABLE}, 32'd0);
         end
         if (c == 2 && aligned)
            chk($sformatf("v%0d_penable_n2", idx), {31'd0, PENABLE}, 32'd1);
         PREADY    = (c >= 2 + v.waits);
         PRDATA    = v.prdata;
         PSLAVEERR = v.slverr;
      end
      PREADY = 1'b0;
      PSLAVEERR = 1'b0;
      chk($sformatf("v%0d_latency", idx), first, v.exp_lat);
      chk($sformatf("v%0d_valid_count", idx), nvalid, 32'd1);
      chk($sformatf("v%0d_err", idx), {31'd0, got_err}, {31'd0, v.exp_err});
      chk($sformatf("v%0d_timeout", idx), {31'd0, got_to}, {31'd0, v.exp_to});
      chk($sformatf("v%0d_rdata", idx), got_rdata, v.exp_rdata);
      chk($sformatf("v%0d_psel_seen", idx), {31'd0, psel_seen}, {31'd0, aligned});
      chk($sformatf("v%0d_bus_stable", idx), {31'd0, bus_bad}, 32'd0);
   endtask

   initial begin
      //        write addr          wdata          waits prdata         err  lat e  to rdata
      vecs[0] = '{1'b1, 32'h0000_0004, 32'h0000_03E8, 0,   32'h0000_0000, 1'b0, 3, 1'b0, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 32'h0000_0000, 32'h0,         3,   32'h0000_00FF, 1'b0, 6, 1'b0, 1'b0, 32'h0000_00FF};
      vecs[2] = '{1'b0, 32'h0000_0008, 32'h0,         0,   32'h0000_DEAD, 1'b1, 3, 1'b1, 1'b0, 32'h0};
      vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         255, 32'h0000_BEEF, 1'b0, 6, 1'b1, 1'b1, 32'h0};
      vecs[4] = '{1'b0, 32'h0000_0006, 32'h0,         0,   32'h0000_1111, 1'b0, 1, 1'b1, 1'b0, 32'h0};
      vecs[5] = '{1'b0, 32'h0000_000C, 32'h0,         3,   32'h1234_5678, 1'b0, 6, 1'b0, 1'b0, 32'h1234_5678};
      vecs[6] = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1,   32'h0000_0000, 1'b1, 4, 1'b1, 1'b0, 32'h0};
      vecs[7] = '{1'b1, 32'h0000_0001, 32'h5555_5555, 0,   32'h0000_0000, 1'b0, 1, 1'b1, 1'b0, 32'h0};
      vecs[8] = '{1'b1, 32'h0000_0024, 32'h0BAD_0BAD, 2,   32'h0000_AAAA, 1'b0, 5, 1'b0, 1'b0, 32'h0};

      PRESETn = 1'b0;
      step(); step(); step();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_psel_penable", {30'd0, PSEL, PENABLE}, 32'd0);
      chk("rst_paddr", PADDR, 32'd0);
      chk("rst_rsp_bits", {29'd0, rsp_err, rsp_timeout, PWRITE}, 32'd0);
      PRESETn = 1'b1;
      step();
      chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

      for (int i = 0; i < 9; i++) run_vec(i);

      // Reset in the middle of an ACCESS phase
      wait_ready();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0014; PREADY = 1'b0;
      step();
      req_valid = 1'b0;
      step();
      chk("mid_rst_in_access", {30'd0, PSEL, PENABLE}, 32'd3);
      PRESETn = 1'b0;
      step();
      chk("mid_rst_bus_drop", {30'd0, PSEL, PENABLE}, 32'd0);
      chk("mid_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      PRESETn = 1'b1;
      begin
         int seen = 0;
         for (int c = 0; c < 6; c++) begin
            step();
            if (rsp_valid === 1'b1 || PSEL === 1'b1) seen++;
         end
         chk("mid_rst_quiet_after", seen, 32'd0);
      end
      chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);

      // Controller still operational after the abort
      run_vec(0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
